// File: rtl/ddr_splice_line_buf.sv
// Ping-pong line buffer between a DDR beat reader and an HDMI raster.
// Splices CH_ROWS x CH_COLS channel tiles (or one full-screen channel) into lines.
module ddr_splice_line_buf #(
   parameter int          DQ_WIDTH = 32,
   parameter int          H_WIDTH  = 1280,
   parameter int          H_HEIGHT = 720,
   parameter int          CH_COLS  = 2,
   parameter int          CH_ROWS  = 2,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 buf_wr_en,
   input  logic [DQ_WIDTH*8-1:0]                buf_wr_data,
   input  logic                                 mode_full,
   input  logic [$clog2(CH_COLS*CH_ROWS)-1:0]   full_ch,
   output logic [$clog2(CH_COLS*CH_ROWS)-1:0]   channel_sel,
   output logic                                 line_req,
   input  logic                                 hdmi_vsync,
   input  logic                                 hdmi_href,
   output logic                                 de_o,
   output logic [15:0]                          rgb565_out,
   output logic                                 underflow
);

   localparam int BW        = DQ_WIDTH * 8;
   localparam int PPB       = BW / 16;
   localparam int BEATS     = H_WIDTH / PPB;
   localparam int SEG_BEATS = BEATS / CH_COLS;
   localparam int LPT       = H_HEIGHT / CH_ROWS;
   localparam int CW        = $clog2(CH_COLS * CH_ROWS);
   localparam int BIW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int RBW       = $clog2(BEATS + 1);
   localparam int SUBW      = (PPB > 1) ? $clog2(PPB) : 1;
   localparam int SBW       = (SEG_BEATS > 1) ? $clog2(SEG_BEATS) : 1;
   localparam int SGW       = (CH_COLS > 1) ? $clog2(CH_COLS) : 1;
   localparam int RW        = (CH_ROWS > 1) ? $clog2(CH_ROWS) : 1;
   localparam int LW        = (H_HEIGHT > 1) ? $clog2(H_HEIGHT) : 1;
   localparam int TLW       = (LPT > 1) ? $clog2(LPT) : 1;

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_t;
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} wr_state_t;

   wr_state_t        wr_st;
   bank_t            bank_st [2];
   logic             wr_bank, oldest;
   logic [BIW-1:0]   beat_idx;
   logic [SBW-1:0]   seg_beat;
   logic [SGW-1:0]   seg;
   logic [LW-1:0]    wr_line;
   logic [TLW-1:0]   tile_line;
   logic [RW-1:0]    tile_row;
   logic             mode_q;
   logic [CW-1:0]    full_ch_q;
   logic             vsync_d, href_d;
   logic             rd_active, rd_bank;
   logic [SUBW-1:0]  rd_sub, s1_sub;
   logic [RBW-1:0]   rd_beat;
   logic             s1_valid, s1_show;
   logic [BW-1:0]    rd_word;
   logic [BW-1:0]    mem [2][BEATS];

   logic             vsync_rise, href_rise, href_fall, accept, last_beat, any_full;
   logic             rise_bank, cur_bank, cur_ok, in_range;
   logic [1:0]       full_now, empty_now;
   logic [SUBW-1:0]  cur_sub;
   logic [RBW-1:0]   cur_beat;
   logic [BIW-1:0]   rd_addr;

   always_comb begin
      vsync_rise   = hdmi_vsync & ~vsync_d;
      href_rise    = hdmi_href & ~href_d;
      href_fall    = ~hdmi_href & href_d;
      accept       = (wr_st == S_FILL) & buf_wr_en & ~vsync_rise;
      last_beat    = accept & (beat_idx == BIW'(BEATS - 1));
      // A bank finishing this cycle is already readable, and one released this cycle already writable.
      full_now[0]  = (bank_st[0] == B_FULL) | (last_beat & ~wr_bank);
      full_now[1]  = (bank_st[1] == B_FULL) | (last_beat & wr_bank);
      empty_now[0] = (bank_st[0] == B_EMPTY) | (href_fall & rd_active & ~rd_bank);
      empty_now[1] = (bank_st[1] == B_EMPTY) | (href_fall & rd_active & rd_bank);
      any_full     = |full_now;
      rise_bank    = (full_now[0] & full_now[1]) ? oldest : full_now[1];
      cur_bank     = href_rise ? rise_bank : rd_bank;
      cur_ok       = href_rise ? any_full : rd_active;
      cur_sub      = href_rise ? '0 : rd_sub;
      cur_beat     = href_rise ? '0 : rd_beat;
      in_range     = cur_beat < RBW'(BEATS);
      rd_addr      = in_range ? BIW'(cur_beat) : '0;
   end

   assign line_req    = (wr_st == S_FILL);
   assign channel_sel = mode_q ? full_ch_q : CW'(int'(tile_row) * CH_COLS + int'(seg));

   // NOTE: line storage carries no reset; bank state flags alone decide whether its contents are shown.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_bank][beat_idx] <= buf_wr_data;
      if (hdmi_href) rd_word <= mem[cur_bank][rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_st      <= S_IDLE;
         bank_st[0] <= B_EMPTY;
         bank_st[1] <= B_EMPTY;
         wr_bank    <= 1'b0;
         oldest     <= 1'b0;
         beat_idx   <= '0;
         seg_beat   <= '0;
         seg        <= '0;
         wr_line    <= '0;
         tile_line  <= '0;
         tile_row   <= '0;
         mode_q     <= 1'b0;
         full_ch_q  <= '0;
         vsync_d    <= 1'b0;
         href_d     <= 1'b0;
         rd_active  <= 1'b0;
         rd_bank    <= 1'b0;
         rd_sub     <= '0;
         rd_beat    <= '0;
         s1_valid   <= 1'b0;
         s1_show    <= 1'b0;
         s1_sub     <= '0;
         de_o       <= 1'b0;
         rgb565_out <= BG_COLOR;
         underflow  <= 1'b0;
      end else begin
         vsync_d    <= hdmi_vsync;
         href_d     <= hdmi_href;
         s1_valid   <= hdmi_href;
         de_o       <= s1_valid;
         rgb565_out <= (s1_valid && s1_show) ? rd_word[int'(s1_sub) * 16 +: 16] : BG_COLOR;

         if (hdmi_href) begin
            s1_show <= cur_ok & in_range;
            s1_sub  <= cur_sub;
            if (cur_sub == SUBW'(PPB - 1)) begin
               rd_sub  <= '0;
               rd_beat <= in_range ? cur_beat + 1'b1 : cur_beat;
            end else begin
               rd_sub  <= cur_sub + 1'b1;
               rd_beat <= cur_beat;
            end
         end else begin
            s1_show <= 1'b0;
         end

         if (href_rise) begin
            rd_bank   <= rise_bank;
            rd_active <= any_full;
            if (!any_full) underflow <= 1'b1;
         end else if (href_fall && rd_active) begin
            bank_st[rd_bank] <= B_EMPTY;
            rd_active        <= 1'b0;
         end

         case (wr_st)
            S_IDLE: if (|empty_now) begin
               wr_bank           <= ~empty_now[0];
               bank_st[~empty_now[0]] <= B_FILLING;
               wr_st             <= S_FILL;
            end
            S_FILL: if (accept) begin
               if (last_beat) begin
                  bank_st[wr_bank] <= B_FULL;
                  if (bank_st[~wr_bank] != B_FULL) oldest <= wr_bank;
                  beat_idx <= '0;
                  seg_beat <= '0;
                  seg      <= '0;
                  wr_st    <= S_WAIT;
                  if (wr_line == LW'(H_HEIGHT - 1)) begin
                     wr_line   <= '0;
                     tile_line <= '0;
                     tile_row  <= '0;
                  end else begin
                     wr_line <= wr_line + 1'b1;
                     if (tile_line == TLW'(LPT - 1)) begin
                        tile_line <= '0;
                        tile_row  <= (tile_row == RW'(CH_ROWS - 1)) ? '0 : tile_row + 1'b1;
                     end else begin
                        tile_line <= tile_line + 1'b1;
                     end
                  end
               end else begin
                  beat_idx <= beat_idx + 1'b1;
                  if (seg_beat == SBW'(SEG_BEATS - 1)) begin
                     seg_beat <= '0;
                     seg      <= seg + 1'b1;
                  end else begin
                     seg_beat <= seg_beat + 1'b1;
                  end
               end
            end
            S_WAIT: if (empty_now[~wr_bank]) begin
               wr_bank            <= ~wr_bank;
               bank_st[~wr_bank]  <= B_FILLING;
               wr_st              <= S_FILL;
            end
            default: wr_st <= S_IDLE;
         endcase

         // Frame start wins over everything above: partial line dropped, mode re-latched.
         if (vsync_rise) begin
            wr_st      <= S_IDLE;
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            rd_active  <= 1'b0;
            wr_bank    <= 1'b0;
            beat_idx   <= '0;
            seg_beat   <= '0;
            seg        <= '0;
            wr_line    <= '0;
            tile_line  <= '0;
            tile_row   <= '0;
            mode_q     <= mode_full;
            full_ch_q  <= full_ch;
            underflow  <= 1'b0;
         end
      end
   end

endmodule
